// File: rtl/ex_forward_interlock.sv
// EX-stage operand forwarding with a load-use interlock that holds stall across a
// variable-latency data-memory response, plus a timeout flag and a stall-cycle counter.
module ex_forward_interlock #(
  parameter int XLEN     = 32,
  parameter int REG_AW   = 5,
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic              ex_uses_rs1,
  input  logic              ex_uses_rs2,
  input  logic [REG_AW-1:0] ex_mem_rd,
  input  logic              ex_mem_regwrite,
  input  logic              ex_mem_memtoreg,
  input  logic [XLEN-1:0]   ex_mem_result,
  input  logic [REG_AW-1:0] mem_wb_rd,
  input  logic              mem_wb_regwrite,
  input  logic [XLEN-1:0]   mem_wb_result,
  input  logic              mem_rdata_valid,
  output logic              ex_stall,
  output logic              ex_bubble,
  output logic [1:0]        fwd_rs1_sel,
  output logic [XLEN-1:0]   fwd_rs1_data,
  output logic [1:0]        fwd_rs2_sel,
  output logic [XLEN-1:0]   fwd_rs2_data,
  output logic [CNT_W-1:0]  stall_count,
  output logic              wait_timeout
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);

  localparam logic [1:0] SEL_RF    = 2'd0;
  localparam logic [1:0] SEL_EXMEM = 2'd1;
  localparam logic [1:0] SEL_MEMWB = 2'd2;

  typedef enum logic {ST_RUN, ST_WAIT} state_t;

  typedef struct packed {
    logic [1:0]      sel;
    logic [XLEN-1:0] data;
  } fwd_t;

  state_t              state, state_nxt;
  logic [REG_AW-1:0]   pend_rd, pend_rd_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic                timeout_set;
  logic                stall_raw;
  logic                hz;
  fwd_t                fwd_rs1, fwd_rs2;

  // A source waiting on an outstanding load must not pick up the stale MEM/WB copy.
  function automatic fwd_t pick_source(input logic [REG_AW-1:0] src, input logic uses);
    fwd_t f;
    f = '{sel: SEL_RF, data: '0};
    if (uses && (src != '0) && !((state == ST_WAIT) && (src == pend_rd))) begin
      if (ex_mem_regwrite && !ex_mem_memtoreg && (ex_mem_rd == src)) begin
        f = '{sel: SEL_EXMEM, data: ex_mem_result};
      end else if (mem_wb_regwrite && (mem_wb_rd == src)) begin
        f = '{sel: SEL_MEMWB, data: mem_wb_result};
      end
    end
    return f;
  endfunction

  assign hz = ex_mem_regwrite && ex_mem_memtoreg && (ex_mem_rd != '0) &&
              ((ex_uses_rs1 && (ex_mem_rd == ex_rs1)) ||
               (ex_uses_rs2 && (ex_mem_rd == ex_rs2)));

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt    = state;
    pend_rd_nxt  = pend_rd;
    wait_cnt_nxt = wait_cnt;
    timeout_set  = 1'b0;
    stall_raw    = 1'b0;
    case (state)
      ST_RUN: begin
        stall_raw = hz;
        if (hz && !mem_rdata_valid) begin
          state_nxt    = ST_WAIT;
          pend_rd_nxt  = ex_mem_rd;
          wait_cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        stall_raw = 1'b1;
        if (mem_rdata_valid) begin
          state_nxt = ST_RUN;
        end else if (wait_cnt == WAIT_W'(MAX_WAIT)) begin
          timeout_set = 1'b1;
          state_nxt   = ST_RUN;
        end else begin
          wait_cnt_nxt = wait_cnt + 1'b1;
        end
      end
      default: state_nxt = ST_RUN;
    endcase
  end

  // NOTE: outputs are gated by rst_n directly so they drop the instant reset asserts,
  // without waiting for a clock edge.
  always_comb begin
    fwd_rs1 = pick_source(ex_rs1, ex_uses_rs1);
    fwd_rs2 = pick_source(ex_rs2, ex_uses_rs2);
    if (!rst_n) begin
      fwd_rs1 = '{sel: SEL_RF, data: '0};
      fwd_rs2 = '{sel: SEL_RF, data: '0};
    end
  end

  assign ex_stall     = rst_n & stall_raw;
  assign ex_bubble    = ex_stall;
  assign fwd_rs1_sel  = fwd_rs1.sel;
  assign fwd_rs1_data = fwd_rs1.data;
  assign fwd_rs2_sel  = fwd_rs2.sel;
  assign fwd_rs2_data = fwd_rs2.data;

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_RUN;
      pend_rd      <= '0;
      wait_cnt     <= '0;
      stall_count  <= '0;
      wait_timeout <= 1'b0;
    end else begin
      state    <= state_nxt;
      pend_rd  <= pend_rd_nxt;
      wait_cnt <= wait_cnt_nxt;
      if (timeout_set) begin
        wait_timeout <= 1'b1;
      end
      if (ex_stall && (stall_count != '1)) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ex_forward_interlock.sv
// Self-checking bench: directed cases with literal expectations, then randomized
// traffic compared every cycle against a behavioural model of the interlock.
module tb_ex_forward_interlock;

  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = 16;
  localparam int SAT_W    = 4;

  logic              clk;
  logic              rst_n;
  logic [REG_AW-1:0] ex_rs1, ex_rs2, ex_mem_rd, mem_wb_rd;
  logic              ex_uses_rs1, ex_uses_rs2;
  logic              ex_mem_regwrite, ex_mem_memtoreg, mem_wb_regwrite, mem_rdata_valid;
  logic [XLEN-1:0]   ex_mem_result, mem_wb_result;

  logic              ex_stall, ex_bubble, wait_timeout;
  logic [1:0]        fwd_rs1_sel, fwd_rs2_sel;
  logic [XLEN-1:0]   fwd_rs1_data, fwd_rs2_data;
  logic [CNT_W-1:0]  stall_count;

  logic              s_ex_stall, s_ex_bubble, s_wait_timeout;
  logic [1:0]        s_fwd_rs1_sel, s_fwd_rs2_sel;
  logic [XLEN-1:0]   s_fwd_rs1_data, s_fwd_rs2_data;
  logic [SAT_W-1:0]  s_stall_count;

  int n_checks = 0;
  int n_errors = 0;

  ex_forward_interlock #(.XLEN(XLEN), .REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memtoreg(ex_mem_memtoreg),
    .ex_mem_result(ex_mem_result), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_result(mem_wb_result), .mem_rdata_valid(mem_rdata_valid),
    .ex_stall(ex_stall), .ex_bubble(ex_bubble),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs1_data(fwd_rs1_data),
    .fwd_rs2_sel(fwd_rs2_sel), .fwd_rs2_data(fwd_rs2_data),
    .stall_count(stall_count), .wait_timeout(wait_timeout)
  );

  ex_forward_interlock #(.XLEN(XLEN), .REG_AW(REG_AW), .MAX_WAIT(MAX_WAIT), .CNT_W(SAT_W)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_uses_rs1(ex_uses_rs1), .ex_uses_rs2(ex_uses_rs2),
    .ex_mem_rd(ex_mem_rd), .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_memtoreg(ex_mem_memtoreg),
    .ex_mem_result(ex_mem_result), .mem_wb_rd(mem_wb_rd), .mem_wb_regwrite(mem_wb_regwrite),
    .mem_wb_result(mem_wb_result), .mem_rdata_valid(mem_rdata_valid),
    .ex_stall(s_ex_stall), .ex_bubble(s_ex_bubble),
    .fwd_rs1_sel(s_fwd_rs1_sel), .fwd_rs1_data(s_fwd_rs1_data),
    .fwd_rs2_sel(s_fwd_rs2_sel), .fwd_rs2_data(s_fwd_rs2_data),
    .stall_count(s_stall_count), .wait_timeout(s_wait_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit m_wait, n_wait;
  int m_pend, n_pend;
  int m_waited, n_waited;
  bit m_to, n_to;
  int m_stalls, n_stalls;

  function automatic void exp_fwd(input int src, input bit uses, output int sel, output longint data);
    sel = 0; data = 0;
    if (!uses || src == 0) return;
    if (m_wait && src == m_pend) return;
    if (ex_mem_regwrite && !ex_mem_memtoreg && int'(ex_mem_rd) == src) begin
      sel = 1; data = longint'(ex_mem_result);
    end else if (mem_wb_regwrite && int'(mem_wb_rd) == src) begin
      sel = 2; data = longint'(mem_wb_result);
    end
  endfunction

  function automatic int sat(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  always @(negedge rst_n) begin
    m_wait = 0; m_pend = 0; m_waited = 0; m_to = 0; m_stalls = 0;
    n_wait = 0; n_pend = 0; n_waited = 0; n_to = 0; n_stalls = 0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_wait = n_wait; m_pend = n_pend; m_waited = n_waited; m_to = n_to; m_stalls = n_stalls;
    end
  end

  always @(negedge clk) begin
    bit     hz, stall;
    int     sel1, sel2;
    longint d1, d2;
    if (!rst_n) begin
      stall = 0; sel1 = 0; sel2 = 0; d1 = 0; d2 = 0;
    end else begin
      hz = ex_mem_regwrite && ex_mem_memtoreg && ex_mem_rd != 0 &&
           ((ex_uses_rs1 && ex_mem_rd == ex_rs1) || (ex_uses_rs2 && ex_mem_rd == ex_rs2));
      stall = m_wait || hz;
      exp_fwd(int'(ex_rs1), ex_uses_rs1, sel1, d1);
      exp_fwd(int'(ex_rs2), ex_uses_rs2, sel2, d2);
    end
    check("m_stall",     ex_stall,       stall);
    check("m_bubble",    ex_bubble,      stall);
    check("m_sel1",      fwd_rs1_sel,    sel1);
    check("m_data1",     fwd_rs1_data,   d1);
    check("m_sel2",      fwd_rs2_sel,    sel2);
    check("m_data2",     fwd_rs2_data,   d2);
    check("m_count",     stall_count,    sat(m_stalls, CNT_W));
    check("m_timeout",   wait_timeout,   m_to);
    check("m_s_stall",   s_ex_stall,     stall);
    check("m_s_bubble",  s_ex_bubble,    stall);
    check("m_s_sel1",    s_fwd_rs1_sel,  sel1);
    check("m_s_data1",   s_fwd_rs1_data, d1);
    check("m_s_sel2",    s_fwd_rs2_sel,  sel2);
    check("m_s_data2",   s_fwd_rs2_data, d2);
    check("m_s_count",   s_stall_count,  sat(m_stalls, SAT_W));
    check("m_s_timeout", s_wait_timeout, m_to);
    if (rst_n) begin
      n_wait = m_wait; n_pend = m_pend; n_waited = m_waited; n_to = m_to;
      n_stalls = m_stalls + (stall ? 1 : 0);
      if (!m_wait) begin
        if (hz && !mem_rdata_valid) begin
          n_wait = 1; n_pend = int'(ex_mem_rd); n_waited = 0;
        end
      end else if (mem_rdata_valid) begin
        n_wait = 0;
      end else if (m_waited == MAX_WAIT) begin
        n_to = 1; n_wait = 0;
      end else begin
        n_waited = m_waited + 1;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    ex_rs1 = '0; ex_rs2 = '0; ex_uses_rs1 = 0; ex_uses_rs2 = 0;
    ex_mem_rd = '0; ex_mem_regwrite = 0; ex_mem_memtoreg = 0; ex_mem_result = '0;
    mem_wb_rd = '0; mem_wb_regwrite = 0; mem_wb_result = '0; mem_rdata_valid = 0;
  endtask

  function automatic logic [REG_AW-1:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return REG_AW'(0);
      1:       return REG_AW'(1);
      2:       return REG_AW'(2);
      default: return REG_AW'(7);
    endcase
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    clr();
    #2;
    check("rst_stall", ex_stall, 0);
    check("rst_count", stall_count, 0);
    check("rst_timeout", wait_timeout, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // ALU forwarding, EX/MEM priority over MEM/WB
    ex_mem_rd = 5; ex_mem_regwrite = 1; ex_mem_result = 32'h11;
    mem_wb_rd = 5; mem_wb_regwrite = 1; mem_wb_result = 32'h22;
    ex_rs1 = 5; ex_uses_rs1 = 1; ex_rs2 = 9; ex_uses_rs2 = 1;
    @(negedge clk);
    check("alu_sel1", fwd_rs1_sel, 1);
    check("alu_data1", fwd_rs1_data, 32'h11);
    check("alu_stall", ex_stall, 0);
    tick();
    ex_mem_regwrite = 0;
    @(negedge clk);
    check("wb_sel1", fwd_rs1_sel, 2);
    check("wb_data1", fwd_rs1_data, 32'h22);
    tick();

    // x0 and unused source
    clr();
    ex_mem_regwrite = 1; mem_wb_regwrite = 1; ex_uses_rs1 = 1; ex_uses_rs2 = 1;
    @(negedge clk);
    check("x0_sel1", fwd_rs1_sel, 0);
    check("x0_sel2", fwd_rs2_sel, 0);
    tick();
    clr();
    ex_mem_rd = 5; ex_mem_regwrite = 1; ex_mem_result = 32'h33; ex_rs2 = 5;
    @(negedge clk);
    check("unused_sel2", fwd_rs2_sel, 0);
    check("unused_data2", fwd_rs2_data, 0);
    tick();

    // single-cycle load-use
    clr();
    ex_mem_rd = 7; ex_mem_regwrite = 1; ex_mem_memtoreg = 1;
    ex_rs2 = 7; ex_uses_rs2 = 1; ex_rs1 = 1; mem_rdata_valid = 1;
    @(negedge clk);
    check("ld1_stall", ex_stall, 1);
    check("ld1_bubble", ex_bubble, 1);
    check("ld1_count0", stall_count, 0);
    tick();
    ex_mem_regwrite = 0; mem_rdata_valid = 0;
    mem_wb_rd = 7; mem_wb_regwrite = 1; mem_wb_result = 32'hABCD;
    @(negedge clk);
    check("ld1_stall_off", ex_stall, 0);
    check("ld1_sel2", fwd_rs2_sel, 2);
    check("ld1_data2", fwd_rs2_data, 32'hABCD);
    check("ld1_count", stall_count, 1);
    tick();

    // multi-cycle load: valid three cycles after detection
    clr();
    ex_mem_rd = 7; ex_mem_regwrite = 1; ex_mem_memtoreg = 1; ex_rs2 = 7; ex_uses_rs2 = 1;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        mem_wb_rd = 7; mem_wb_regwrite = 1; mem_wb_result = 32'h55;
      end
      mem_rdata_valid = (i == 3);
      @(negedge clk);
      check("ldn_stall", ex_stall, 1);
      if (i == 1) check("ldn_stale_sel2", fwd_rs2_sel, 0);
      tick();
    end
    ex_mem_regwrite = 0; mem_rdata_valid = 0; mem_wb_result = 32'hBEEF;
    @(negedge clk);
    check("ldn_stall_off", ex_stall, 0);
    check("ldn_sel2", fwd_rs2_sel, 2);
    check("ldn_data2", fwd_rs2_data, 32'hBEEF);
    check("ldn_count", stall_count, 5);
    tick();

    // timeout: valid never arrives
    clr();
    ex_mem_rd = 7; ex_mem_regwrite = 1; ex_mem_memtoreg = 1; ex_rs1 = 7; ex_uses_rs1 = 1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check("to_stall", ex_stall, 1);
      check("to_flag_low", wait_timeout, 0);
      tick();
    end
    ex_mem_regwrite = 0;
    @(negedge clk);
    check("to_run", ex_stall, 0);
    check("to_flag", wait_timeout, 1);
    check("to_count", stall_count, 22);
    tick();
    tick();
    @(negedge clk);
    check("to_sticky", wait_timeout, 1);
    tick();

    // reset pulsed mid-WAIT
    clr();
    ex_mem_rd = 7; ex_mem_regwrite = 1; ex_mem_memtoreg = 1; ex_rs2 = 7; ex_uses_rs2 = 1;
    ex_rs1 = 4; ex_uses_rs1 = 1; mem_wb_rd = 4; mem_wb_regwrite = 1; mem_wb_result = 32'h1234;
    tick();
    tick();
    tick();
    @(negedge clk);
    check("pre_rst_sel1", fwd_rs1_sel, 2);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_stall", ex_stall, 0);
    check("mid_rst_bubble", ex_bubble, 0);
    check("mid_rst_sel1", fwd_rs1_sel, 0);
    check("mid_rst_data1", fwd_rs1_data, 0);
    check("mid_rst_count", stall_count, 0);
    check("mid_rst_timeout", wait_timeout, 0);
    tick();
    rst_n = 1'b1;

    // saturation: hazard held with no response
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      check("sat_stall", ex_stall, 1);
      tick();
    end
    @(negedge clk);
    check("sat_count_wide", stall_count, 22);
    check("sat_count_narrow", s_stall_count, 15);
    tick();

    // randomized traffic
    for (int cyc = 0; cyc < 3000; cyc++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      ex_rs1 = pick_reg(); ex_rs2 = pick_reg();
      ex_uses_rs1 = ($urandom_range(0, 3) != 0);
      ex_uses_rs2 = ($urandom_range(0, 3) != 0);
      ex_mem_rd = pick_reg(); mem_wb_rd = pick_reg();
      ex_mem_regwrite = ($urandom_range(0, 3) != 0);
      ex_mem_memtoreg = $urandom_range(0, 1) == 1;
      mem_wb_regwrite = ($urandom_range(0, 3) != 0);
      ex_mem_result = $urandom;
      mem_wb_result = $urandom;
      if ((cyc % 600) < 300) mem_rdata_valid = $urandom_range(0, 1) == 1;
      else                   mem_rdata_valid = ($urandom_range(0, 24) == 0);
      tick();
    end
    rst_n = 1'b1;
    clr();
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
